bit_count_unit: RTL and testbench

BIT_COUNT_UNIT -- requirements
Module: bit_count_unit

---
 rtl/bit_count_unit.sv | 65 ++++++
 tb/tb_bit_count_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_count_unit.sv
// Sequential population counter: loads an operand (optionally inverted), then shifts
// it right one bit per cycle, accumulating ones until the remaining operand is zero.
module bit_count_unit #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] data_in,
    output logic [CW-1:0]    result,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] COUNT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       ps;
    logic [WIDTH-1:0] a;

    always_ff @(posedge clk) begin
        if (reset) begin
            ps     <= IDLE;
            a      <= '0;
            result <= '0;
        end else begin
            case (ps)
                IDLE: begin
                    if (start) begin
                        ps <= COUNT;
                    end else begin
                        a      <= mode ? ~data_in : data_in;
                        result <= '0;
                    end
                end
                COUNT: begin
                    // Exit as soon as no set bits remain, so leading zeros cost nothing.
                    if (a != '0) begin
                        a      <= a >> 1;
                        result <= result + CW'(a[0]);
                    end else begin
                        ps <= DONE;
                    end
                end
                DONE: begin
                    if (!start) begin
                        ps     <= IDLE;
                        a      <= mode ? ~data_in : data_in;
                        result <= '0;
                    end
                end
                default: ps <= IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (ps == COUNT);
        done = (ps == DONE);
    end

endmodule

// File: tb/tb_bit_count_unit.sv
// Testbench for bit_count_unit: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, randomized operands, and a WIDTH=16 instance.
module tb_bit_count_unit;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         mode = 1'b0;
    logic [W-1:0] data_in = '0;
    logic [3:0]   result;
    logic         busy;
    logic         done;

    logic         reset16 = 1'b1;
    logic         start16 = 1'b0;
    logic         mode16 = 1'b0;
    logic [15:0]  data16 = '0;
    logic [4:0]   result16;
    logic         busy16;
    logic         done16;

    int n_cmp = 0;
    int n_bad = 0;
    bit check_en = 1'b0;

    bit_count_unit #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .data_in(data_in), .result(result), .busy(busy), .done(done)
    );

    bit_count_unit #(.WIDTH(16)) dut16 (
        .clk(clk), .reset(reset16), .start(start16), .mode(mode16),
        .data_in(data16), .result(result16), .busy(busy16), .done(done16)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Ones among the lowest n bits of op.
    function automatic int pop_low(input logic [W-1:0] op, input int n);
        int c = 0;
        for (int i = 0; i < n; i++) c += int'(op[i]);
        return c;
    endfunction

    // Position of highest set bit plus one; 0 for a zero operand.
    function automatic int msb_k(input logic [W-1:0] op);
        int k = 0;
        for (int i = 0; i < W; i++) if (op[i]) k = i + 1;
        return k;
    endfunction

    // Transaction-level reference: which phase, the captured operand and bits consumed so far.
    localparam int P_IDLE = 0, P_COUNT = 1, P_DONE = 2;
    int           m_phase = P_IDLE;
    logic [W-1:0] m_op = '0;
    int           m_j = 0;
    int           m_k = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_phase = P_IDLE;
            m_op    = '0;
            m_j     = 0;
        end else if (m_phase == P_IDLE) begin
            if (start) begin
                m_phase = P_COUNT;
                m_j     = 0;
                m_k     = msb_k(m_op);
            end else begin
                m_op = mode ? ~data_in : data_in;
            end
        end else if (m_phase == P_COUNT) begin
            if (m_j < m_k) m_j++;
            else m_phase = P_DONE;
        end else if (!start) begin
            m_phase = P_IDLE;
            m_op    = mode ? ~data_in : data_in;
        end
        check_en = 1'b1;
    end

    always @(negedge clk) begin
        if (check_en) begin
            int exp_res;
            exp_res = (m_phase == P_COUNT) ? pop_low(m_op, m_j) :
                      (m_phase == P_DONE)  ? pop_low(m_op, W) : 0;
            check("model busy", 32'(busy), 32'(m_phase == P_COUNT));
            check("model done", 32'(done), 32'(m_phase == P_DONE));
            check("model result", 32'(result), 32'(exp_res));
        end
    end

    // Called at a negedge with the operand already loaded; returns after done is seen.
    task automatic run_count(input string name, input int exp_res, input int exp_edges);
        int n = 0;
        start = 1'b1;
        @(posedge clk);
        do begin
            @(posedge clk);
            n++;
            #1;
        end while (!done && n < 40);
        check({name, " edges"}, 32'(n), 32'(exp_edges));
        check({name, " result"}, 32'(result), 32'(exp_res));
    endtask

    task automatic load(input logic [W-1:0] d, input logic m);
        @(negedge clk);
        start   = 1'b0;
        data_in = d;
        mode    = m;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] d, op;
        logic         m;

        repeat (2) @(posedge clk);
        #1;
        check("reset busy", 32'(busy), 0);
        check("reset done", 32'(done), 0);
        check("reset result", 32'(result), 0);
        @(negedge clk);
        reset = 1'b0;

        load(8'hA6, 1'b0);
        run_count("basic A6", 4, 9);
        repeat (5) begin
            @(posedge clk);
            #1;
            check("hold done", 32'(done), 1);
            check("hold result", 32'(result), 4);
        end
        @(negedge clk);
        start   = 1'b0;
        data_in = 8'h01;
        mode    = 1'b0;
        @(posedge clk);
        #1;
        check("release done", 32'(done), 0);
        check("release busy", 32'(busy), 0);
        @(negedge clk);
        run_count("restart 01", 1, 2);

        load(8'h00, 1'b0);
        run_count("zero", 0, 1);
        load(8'h05, 1'b0);
        run_count("early 05", 2, 4);
        load(8'hFF, 1'b0);
        run_count("full FF", 8, 9);
        load(8'h0F, 1'b1);
        run_count("zeros 0F", 4, 9);

        // Reset landing mid-count.
        load(8'hFF, 1'b0);
        start = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("midreset busy", 32'(busy), 0);
        check("midreset done", 32'(done), 0);
        check("midreset result", 32'(result), 0);
        @(negedge clk);
        reset = 1'b0;
        load(8'hFF, 1'b0);
        run_count("after reset FF", 8, 9);

        // Start already high on the first edge after reset release.
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("post-reset start busy", 32'(busy), 1);
        @(posedge clk);
        #1;
        check("post-reset start done", 32'(done), 1);
        check("post-reset start result", 32'(result), 0);

        for (int t = 0; t < 60; t++) begin
            d  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
            m  = 1'($urandom_range(0, 1));
            op = m ? ~d : d;
            load(d, m);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_count("random", pop_low(op, W), msb_k(op) + 1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            @(negedge clk);
            start   = 1'b0;
            data_in = 8'($urandom_range(0, 255));
        end

        // WIDTH=16 instance.
        @(negedge clk);
        reset16 = 1'b0;
        start16 = 1'b0;
        data16  = 16'hFFFF;
        mode16  = 1'b0;
        @(negedge clk);
        start16 = 1'b1;
        @(posedge clk);
        begin
            int n = 0;
            do begin
                @(posedge clk);
                n++;
                #1;
                if (n == 1) check("w16 busy", 32'(busy16), 1);
            end while (!done16 && n < 60);
            check("w16 edges", 32'(n), 17);
            check("w16 result", 32'(result16), 16);
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
